wfifo_burst_sched: RTL and testbench
====================================

Name: wfifo_burst_sched

Overview:
Two-channel write-burst scheduler that drains a pair of 32-bit prefetch (first-word-fall-through) capture FIFOs into a shared DDR write command/data port.
- Arbitrates round-robin between channels that report a full burst buffered.
- Issues one command per burst (word address, length), then streams exactly BURST_LEN beats from the granted FIFO.
- Maintains a per-channel circular write pointer inside that channel's DDR region.
- Sits between the oscilloscope capture FIFOs (read side) and the DDR write interface, all on the DDR user clock.

Parameters:
DATA_WIDTH, 32, FIFO and DDR write data width
ADDR_WIDTH, 28, DDR word address width
BURST_LEN, 16, beats per burst (power of two, 2..256)
REGION_LOG2, 20, log2 of per-channel circular region size in words (≥ log2 BURST_LEN)

Ports:
clk  input  1  DDR user clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  permit new bursts to start
ch0_burst_rdy  input  1  ch0 FIFO holds ≥BURST_LEN words (upstream guarantee)
ch0_rd_vld  input  1  ch0 FIFO head word valid
ch0_rd_data  input  DATA_WIDTH  ch0 FIFO head word
ch0_rd_en  output  1  pop ch0 FIFO head
ch0_base_addr  input  ADDR_WIDTH  ch0 region base, word address
ch1_burst_rdy, ch1_rd_vld, ch1_rd_data, ch1_rd_en, ch1_base_addr  same as ch0 for channel 1
cmd_valid  output  1  write command valid
cmd_ready  input  1  DDR accepts command
cmd_addr  output  ADDR_WIDTH  burst start word address
cmd_len  output  8  BURST_LEN-1
cmd_ch  output  1  granted channel
wdata_valid  output  1  write beat valid
wdata_ready  input  1  DDR accepts beat
wdata  output  DATA_WIDTH  write beat data
wdata_last  output  1  final beat of burst
busy  output  1  FSM not IDLE
ch0_offset, ch1_offset  output  REGION_LOG2  current circular write offset per channel

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, offsets=0, last_grant=1 (so ch0 wins first tie), every output 0 (cmd_len constant BURST_LEN-1 allowed).
- FSM states: IDLE, CMD, DATA.
- IDLE: if enable and any chN_burst_rdy:
  - Grant ch0 or ch1; if both request, grant the channel ≠ last_grant.
  - Register grant; last_grant←grant; next cycle CMD.
  - No request or enable=0: stay IDLE.
- CMD:
  - cmd_valid=1; cmd_addr = base_addr[grant] + zero-extended offset[grant], truncated to ADDR_WIDTH; cmd_ch=grant.
  - Outputs held stable until cmd_valid&cmd_ready, then DATA with beat counter=0.
- DATA:
  - wdata_valid = rd_vld[grant]; wdata = rd_data[grant] (combinational pass-through, zero added latency).
  - rd_en[grant] = wdata_valid & wdata_ready; non-granted rd_en always 0.
  - wdata_last = wdata_valid & (beat==BURST_LEN-1).
  - Beat counter increments on each handshake.
  - On last handshake: offset[grant] ← (offset + BURST_LEN) mod 2^REGION_LOG2 (natural wrap); go to IDLE.
- Minimum one IDLE cycle between bursts. Command-to-first-beat latency: first DATA cycle after cmd handshake.
- FIFO underrun mid-burst (rd_vld=0): wdata_valid=0, counter holds, no timeout.
- wdata_ready low: data held, no pop.
- enable deasserted during CMD/DATA: current burst completes; gating applies only in IDLE.
- burst_rdy deasserting after grant is ignored.
- base_addr sampled only while in CMD; software changes it only while busy=0.
- Reset mid-burst: immediate return to reset values; partial burst abandoned, no further pops.

Test Plan:
- Reset then ch0_burst_rdy=1, base=0x100, BURST_LEN=16, cmd_ready=1, wdata_ready=1, FIFO data 0..15 → cmd_addr=0x100, cmd_len=15, cmd_ch=0; 16 beats 0..15; wdata_last only on beat 15; ch0_offset=16; exactly 16 ch0_rd_en pulses.
- Both channels ready continuously → grants alternate ch0, ch1, ch0, ch1; ch1 bursts at ch1_base+0,+16; no ch0/ch1 rd_en overlap.
- cmd_ready low 5 cycles → cmd_valid/addr stable 5 cycles, no rd_en; wdata_ready toggled 1/0 each cycle → 16 beats over ~32 cycles, data order intact.
- ch0_rd_vld dropped for 3 cycles at beat 7 → wdata_valid low 3 cycles, beat 7 data then resumes; total still 16 beats.
- REGION_LOG2=5, offset=16 → cmd_addr=base+16, next offset wraps to 0, next cmd_addr=base+0.
- Assert rst_n=0 at beat 5 → all outputs 0 same cycle, offsets 0; after release with enable=0 → no cmd_valid.

Source files
------------

// File: rtl/wfifo_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : wfifo_burst_sched
// Description : Two-channel round-robin write-burst scheduler draining FWFT
//               capture FIFOs into a DDR write command/data port.
// Revision    : 1.0 - initial release
// ============================================================================
module wfifo_burst_sched #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 28,
  parameter int BURST_LEN   = 16,
  parameter int REGION_LOG2 = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic                   ch0_burst_rdy,
  input  logic                   ch0_rd_vld,
  input  logic [DATA_WIDTH-1:0]  ch0_rd_data,
  output logic                   ch0_rd_en,
  input  logic [ADDR_WIDTH-1:0]  ch0_base_addr,
  input  logic                   ch1_burst_rdy,
  input  logic                   ch1_rd_vld,
  input  logic [DATA_WIDTH-1:0]  ch1_rd_data,
  output logic                   ch1_rd_en,
  input  logic [ADDR_WIDTH-1:0]  ch1_base_addr,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ADDR_WIDTH-1:0]  cmd_addr,
  output logic [7:0]             cmd_len,
  output logic                   cmd_ch,
  output logic                   wdata_valid,
  input  logic                   wdata_ready,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic                   wdata_last,
  output logic                   busy,
  output logic [REGION_LOG2-1:0] ch0_offset,
  output logic [REGION_LOG2-1:0] ch1_offset
);

  localparam int c_BEAT_W = $clog2(BURST_LEN);
  localparam logic [c_BEAT_W-1:0]    c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);
  // Truncation to the region width gives the natural circular wrap.
  localparam logic [REGION_LOG2-1:0] c_BURST_INC = REGION_LOG2'(BURST_LEN);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CMD  = 2'd1;
  localparam logic [1:0] c_DATA = 2'd2;

  logic [1:0]             r_state;
  logic                   r_grant;
  logic                   r_last_grant;
  logic [c_BEAT_W-1:0]    r_beat;
  logic [REGION_LOG2-1:0] r_offset0;
  logic [REGION_LOG2-1:0] r_offset1;

  logic                   w_req0;
  logic                   w_req1;
  logic                   w_start;
  logic                   w_pick;
  logic                   w_in_cmd;
  logic                   w_in_data;
  logic                   w_rd_vld;
  logic [DATA_WIDTH-1:0]  w_rd_data;
  logic                   w_fire;
  logic                   w_last_fire;
  logic [REGION_LOG2-1:0] w_offset_sel;
  logic [ADDR_WIDTH-1:0]  w_base_sel;

  assign w_req0  = enable & ch0_burst_rdy;
  assign w_req1  = enable & ch1_burst_rdy;
  assign w_start = w_req0 | w_req1;
  // On a tie the channel that did not win last time gets the grant.
  assign w_pick  = (w_req0 & w_req1) ? ~r_last_grant : w_req1;

  assign w_in_cmd    = (r_state == c_CMD);
  assign w_in_data   = (r_state == c_DATA);
  assign w_rd_vld    = r_grant ? ch1_rd_vld  : ch0_rd_vld;
  assign w_rd_data   = r_grant ? ch1_rd_data : ch0_rd_data;
  assign w_fire      = w_in_data & w_rd_vld & wdata_ready;
  assign w_last_fire = w_fire & (r_beat == c_LAST_BEAT);

  assign w_offset_sel = r_grant ? r_offset1 : r_offset0;
  assign w_base_sel   = r_grant ? ch1_base_addr : ch0_base_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_beat       <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_start) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_state      <= c_CMD;
          end
        end
        c_CMD: begin
          if (cmd_ready) begin
            r_beat  <= '0;
            r_state <= c_DATA;
          end
        end
        c_DATA: begin
          if (w_fire) begin
            r_beat <= r_beat + 1'b1;
            if (r_beat == c_LAST_BEAT) r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_offset0 <= '0;
      r_offset1 <= '0;
    end else if (w_last_fire) begin
      if (r_grant) r_offset1 <= r_offset1 + c_BURST_INC;
      else         r_offset0 <= r_offset0 + c_BURST_INC;
    end
  end

  assign cmd_valid   = w_in_cmd;
  assign cmd_addr    = w_in_cmd ? (w_base_sel + ADDR_WIDTH'(w_offset_sel)) : '0;
  assign cmd_len     = w_in_cmd ? 8'(BURST_LEN - 1) : 8'd0;
  assign cmd_ch      = w_in_cmd & r_grant;
  assign wdata_valid = w_in_data & w_rd_vld;
  assign wdata       = w_in_data ? w_rd_data : '0;
  assign wdata_last  = wdata_valid & (r_beat == c_LAST_BEAT);
  assign ch0_rd_en   = w_fire & ~r_grant;
  assign ch1_rd_en   = w_fire & r_grant;
  assign busy        = (r_state != c_IDLE);
  assign ch0_offset  = r_offset0;
  assign ch1_offset  = r_offset1;

endmodule
`default_nettype wire

// File: tb/tb_wfifo_burst_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_wfifo_burst_sched
// Description : Randomized bench for wfifo_burst_sched with a transaction-level
//               reference model and behavioural FIFOs on both channels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wfifo_burst_sched;

  localparam int BL  = 16;
  localparam int RL2 = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        ch0_burst_rdy = 1'b0, ch1_burst_rdy = 1'b0;
  logic        ch0_rd_vld = 1'b0, ch1_rd_vld = 1'b0;
  logic [31:0] ch0_rd_data = '0, ch1_rd_data = '0;
  logic        ch0_rd_en, ch1_rd_en;
  logic [27:0] ch0_base_addr = 28'h000_0100;
  logic [27:0] ch1_base_addr = 28'hFFF_FFF0;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [27:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        cmd_ch;
  logic        wdata_valid, wdata_ready = 1'b0;
  logic [31:0] wdata;
  logic        wdata_last, busy;
  logic [RL2-1:0] ch0_offset, ch1_offset;

  wfifo_burst_sched #(
    .DATA_WIDTH(32), .ADDR_WIDTH(28), .BURST_LEN(BL), .REGION_LOG2(RL2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ch0_burst_rdy(ch0_burst_rdy), .ch0_rd_vld(ch0_rd_vld), .ch0_rd_data(ch0_rd_data),
    .ch0_rd_en(ch0_rd_en), .ch0_base_addr(ch0_base_addr),
    .ch1_burst_rdy(ch1_burst_rdy), .ch1_rd_vld(ch1_rd_vld), .ch1_rd_data(ch1_rd_data),
    .ch1_rd_en(ch1_rd_en), .ch1_base_addr(ch1_base_addr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_ch(cmd_ch),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .wdata_last(wdata_last), .busy(busy),
    .ch0_offset(ch0_offset), .ch1_offset(ch1_offset)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural FIFOs; words are tagged {channel, per-channel sequence number}
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int p_word[2];
  int m_word[2];

  // Transaction-level reference: phase 0 = waiting, 1 = command, 2 = beats
  int m_phase = 0;
  int m_ch    = 0;
  int m_last  = 1;
  int m_beat  = 0;
  int m_off[2];
  int n_bursts[2];
  bit en_allow = 1'b1;

  initial begin
    m_off = '{0, 0};
    n_bursts = '{0, 0};
    p_word = '{0, 0};
    m_word = '{0, 0};
  end

  // Monitor: inputs settle at posedge+1, checks and model updates at negedge
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check_eq("rst_cmd_valid", {31'd0, cmd_valid}, 0);
        check_eq("rst_wdata_valid", {31'd0, wdata_valid}, 0);
        check_eq("rst_rd_en", {30'd0, ch1_rd_en, ch0_rd_en}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_offsets", {22'd0, ch1_offset, ch0_offset}, 0);
        check_eq("rst_cmd_addr", {4'd0, cmd_addr}, 0);
        check_eq("rst_wdata", wdata, 0);
        check_eq("rst_last", {31'd0, wdata_last}, 0);
        m_phase = 0; m_last = 1; m_beat = 0; m_off = '{0, 0};
      end else begin
        check_eq("ch0_offset", {27'd0, ch0_offset}, m_off[0]);
        check_eq("ch1_offset", {27'd0, ch1_offset}, m_off[1]);
        if (m_phase == 0) begin
          check_eq("idle_busy", {31'd0, busy}, 0);
          check_eq("idle_cmd_valid", {31'd0, cmd_valid}, 0);
          check_eq("idle_wdata_valid", {31'd0, wdata_valid}, 0);
          check_eq("idle_rd_en", {30'd0, ch1_rd_en, ch0_rd_en}, 0);
          if (enable && (ch0_burst_rdy || ch1_burst_rdy)) begin
            m_ch = (ch0_burst_rdy && ch1_burst_rdy) ? 1 - m_last : (ch1_burst_rdy ? 1 : 0);
            m_last = m_ch;
            m_phase = 1;
          end
        end else if (m_phase == 1) begin
          logic [27:0] base;
          base = (m_ch == 1) ? ch1_base_addr : ch0_base_addr;
          check_eq("cmd_valid", {31'd0, cmd_valid}, 1);
          check_eq("cmd_ch", {31'd0, cmd_ch}, m_ch);
          check_eq("cmd_addr", {4'd0, cmd_addr}, (base + m_off[m_ch]) & 32'h0FFF_FFFF);
          check_eq("cmd_len", {24'd0, cmd_len}, BL - 1);
          check_eq("cmd_busy", {31'd0, busy}, 1);
          check_eq("cmd_wdata_valid", {31'd0, wdata_valid}, 0);
          check_eq("cmd_rd_en", {30'd0, ch1_rd_en, ch0_rd_en}, 0);
          if (cmd_ready) begin
            m_phase = 2;
            m_beat = 0;
          end
        end else begin
          bit vld, fire;
          vld  = (m_ch == 1) ? ch1_rd_vld : ch0_rd_vld;
          fire = vld && wdata_ready;
          check_eq("data_busy", {31'd0, busy}, 1);
          check_eq("data_cmd_valid", {31'd0, cmd_valid}, 0);
          check_eq("wdata_valid", {31'd0, wdata_valid}, vld);
          check_eq("own_rd_en", {31'd0, (m_ch == 1) ? ch1_rd_en : ch0_rd_en}, fire);
          check_eq("other_rd_en", {31'd0, (m_ch == 1) ? ch0_rd_en : ch1_rd_en}, 0);
          if (vld) begin
            check_eq("wdata", wdata, {m_ch[0], 31'(m_word[m_ch])});
            check_eq("wdata_last", {31'd0, wdata_last}, (m_beat == BL - 1));
          end
          if (fire) begin
            if (m_ch == 1) void'(q1.pop_front()); else void'(q0.pop_front());
            m_word[m_ch]++;
            m_beat++;
            if (m_beat == BL) begin
              m_off[m_ch] = (m_off[m_ch] + BL) % (1 << RL2);
              n_bursts[m_ch]++;
              m_phase = 0;
            end
          end
        end
      end
      // Upstream producers
      if (q0.size() < 48 && $urandom_range(0, 99) < 60) begin
        q0.push_back({1'b0, 31'(p_word[0])}); p_word[0]++;
      end
      if (q1.size() < 48 && $urandom_range(0, 99) < 60) begin
        q1.push_back({1'b1, 31'(p_word[1])}); p_word[1]++;
      end
    end
  end

  task automatic drive_cycle();
    @(posedge clk);
    #1;
    enable        = en_allow && ($urandom_range(0, 99) < 95);
    cmd_ready     = ($urandom_range(0, 2) != 0);
    wdata_ready   = ($urandom_range(0, 3) != 0);
    ch0_rd_vld    = (q0.size() > 0) && ($urandom_range(0, 99) < 85);
    ch1_rd_vld    = (q1.size() > 0) && ($urandom_range(0, 99) < 85);
    ch0_rd_data   = ch0_rd_vld ? q0[0] : $urandom;
    ch1_rd_data   = ch1_rd_vld ? q1[0] : $urandom;
    ch0_burst_rdy = (q0.size() >= BL);
    ch1_burst_rdy = (q1.size() >= BL);
  endtask

  initial begin
    bit found;
    repeat (4) drive_cycle();
    rst_n = 1'b1;
    repeat (3000) drive_cycle();

    // Reset in the middle of a burst, then stay quiet with enable low
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      drive_cycle();
      if (m_phase == 2 && m_beat == 5) found = 1'b1;
    end
    check_eq("midburst_reached", {31'd0, found}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_cmd_valid", {31'd0, cmd_valid}, 0);
    check_eq("async_wdata_valid", {31'd0, wdata_valid}, 0);
    check_eq("async_rd_en", {30'd0, ch1_rd_en, ch0_rd_en}, 0);
    check_eq("async_offsets", {22'd0, ch1_offset, ch0_offset}, 0);
    check_eq("async_busy", {31'd0, busy}, 0);
    en_allow = 1'b0;
    repeat (3) drive_cycle();
    rst_n = 1'b1;
    repeat (30) drive_cycle();
    en_allow = 1'b1;
    repeat (1500) drive_cycle();

    check_eq("ch0_bursts_seen", {31'd0, n_bursts[0] >= 20}, 1);
    check_eq("ch1_bursts_seen", {31'd0, n_bursts[1] >= 20}, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
